// File: rtl/bayer_window_stream_pkg.sv
// Shared types for the Bayer 3x3 window streamer: tags, colour decode and FSM states.
package bayer_pkg;

  typedef enum logic [1:0] {
    RED               = 2'b00,
    GREEN_BESIDE_BLUE = 2'b01,
    GREEN_BESIDE_RED  = 2'b10,
    BLUE              = 2'b11
  } color_t;

  typedef enum logic [1:0] {
    LAT_CENTER = 2'd0,
    LAT_LEFT   = 2'd1,
    LAT_RIGHT  = 2'd2
  } lateral_t;

  typedef enum logic [1:0] {
    VERT_MIDDLE = 2'd0,
    VERT_TOP    = 2'd1,
    VERT_BOTTOM = 2'd2
  } vertical_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN
  } ws_state_t;

  // Colour follows the {x lsb, y lsb} pair of the centre pixel.
  function automatic color_t bayer_color(input logic x_lsb, input logic y_lsb);
    return color_t'({x_lsb, y_lsb});
  endfunction

endpackage

// File: rtl/bayer_window_stream_line_buffer.sv
// One-row delay line: dout is the sample written DEPTH enabled cycles earlier.
module line_buffer #(
  parameter int DEPTH = 40,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr;

  // Read-before-write at the same slot gives exactly DEPTH advances of delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/bayer_window_stream.sv
// Streaming 3x3 Bayer window generator: two line buffers plus a 3x3 shift array.
// Optional WSTREAM_COORD_EN adds out_x/out_y centre-coordinate ports.
//
// state    | meaning
// ST_IDLE  | waiting for a pixel with in_sof; others are dropped
// ST_FILL  | priming line buffers, no windows until pixel WIDTH+1
// ST_RUN   | one window per accepted pixel, in_ready follows output slot
// ST_DRAIN | input closed, flushing last WIDTH+1 windows with zeros
module bayer_window_stream
  import bayer_pkg::*;
#(
  parameter int WIDTH  = 40,
  parameter int HEIGHT = 30,
  parameter int PIX_W  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sof,
  input  logic [PIX_W-1:0]              in_pixel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:-1][1:-1][PIX_W-1:0]  out_window,
  output lateral_t                      out_lateral,
  output vertical_t                     out_vertical,
  output color_t                        out_color
`ifdef WSTREAM_COORD_EN
  ,
  output logic [$clog2(WIDTH)-1:0]      out_x,
  output logic [$clog2(HEIGHT)-1:0]     out_y
`endif
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  typedef logic [1:-1][1:-1][PIX_W-1:0] win_t;

  ws_state_t      state;
  logic [XW-1:0]  in_x, ctr_x, cur_x;
  logic [YW-1:0]  in_y, ctr_y, cur_y;
  win_t           raw_q, shift_next, win_next;
  logic [PIX_W-1:0] pix_in, lb1_dout, lb2_dout;
  logic           accept, out_hs, sof_take, advance, emit;
  logic           in_last, fill_done, out_last;
  lateral_t       lat_next;
  vertical_t      vert_next;

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE, ST_FILL: in_ready = 1'b1;
        ST_RUN:           in_ready = !out_valid || out_ready;
        default:          in_ready = 1'b0;
      endcase
    end
  end

  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign sof_take  = accept && in_sof;
  assign in_last   = (in_x == XW'(WIDTH - 1)) && (in_y == YW'(HEIGHT - 1));
  assign fill_done = (in_x == XW'(1)) && (in_y == YW'(1));
  assign out_last  = (cur_x == XW'(WIDTH - 1)) && (cur_y == YW'(HEIGHT - 1));
  assign pix_in    = (state == ST_DRAIN) ? '0 : in_pixel;

  always_comb begin
    advance = 1'b0;
    emit    = 1'b0;
    case (state)
      ST_IDLE:  advance = sof_take;
      ST_FILL: begin
        advance = accept;
        emit    = accept && !in_sof && fill_done;
      end
      ST_RUN: begin
        advance = accept;
        emit    = accept && !in_sof;
      end
      ST_DRAIN: begin
        advance = out_hs && !out_last;
        emit    = out_hs && !out_last;
      end
      default: ;
    endcase
  end

  line_buffer #(.DEPTH(WIDTH), .W(PIX_W)) u_lb1 (
    .clk(clk), .reset(reset), .en(advance), .din(pix_in), .dout(lb1_dout)
  );

  line_buffer #(.DEPTH(WIDTH), .W(PIX_W)) u_lb2 (
    .clk(clk), .reset(reset), .en(advance), .din(lb1_dout), .dout(lb2_dout)
  );

  // New right column is {two rows up, one row up, incoming}.
  always_comb begin
    shift_next = raw_q;
    shift_next[-1][-1] = raw_q[-1][0];
    shift_next[0][-1]  = raw_q[0][0];
    shift_next[1][-1]  = raw_q[1][0];
    shift_next[-1][0]  = raw_q[-1][1];
    shift_next[0][0]   = raw_q[0][1];
    shift_next[1][0]   = raw_q[1][1];
    shift_next[-1][1]  = lb2_dout;
    shift_next[0][1]   = lb1_dout;
    shift_next[1][1]   = pix_in;
  end

  // Slots outside the frame are zeroed; the left column would otherwise carry the previous row.
  always_comb begin
    win_next = shift_next;
    if (ctr_y == '0)               win_next[-1] = '0;
    if (ctr_y == YW'(HEIGHT - 1))  win_next[1]  = '0;
    if (ctr_x == '0) begin
      win_next[-1][-1] = '0;
      win_next[0][-1]  = '0;
      win_next[1][-1]  = '0;
    end
    if (ctr_x == XW'(WIDTH - 1)) begin
      win_next[-1][1] = '0;
      win_next[0][1]  = '0;
      win_next[1][1]  = '0;
    end
  end

  always_comb begin
    lat_next  = LAT_CENTER;
    vert_next = VERT_MIDDLE;
    if (ctr_x == '0)                   lat_next  = LAT_LEFT;
    else if (ctr_x == XW'(WIDTH - 1))  lat_next  = LAT_RIGHT;
    if (ctr_y == '0)                   vert_next = VERT_TOP;
    else if (ctr_y == YW'(HEIGHT - 1)) vert_next = VERT_BOTTOM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      out_valid    <= 1'b0;
      out_window   <= '0;
      out_lateral  <= LAT_CENTER;
      out_vertical <= VERT_MIDDLE;
      out_color    <= RED;
      raw_q        <= '0;
      in_x         <= '0;
      in_y         <= '0;
      ctr_x        <= '0;
      ctr_y        <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
    end else begin
      if (advance) raw_q <= shift_next;

      if (sof_take) begin
        state     <= ST_FILL;
        out_valid <= 1'b0;
        in_x      <= XW'(1);
        in_y      <= '0;
        ctr_x     <= '0;
        ctr_y     <= '0;
      end else begin
        if (accept && state != ST_IDLE) begin
          if (in_x == XW'(WIDTH - 1)) begin
            in_x <= '0;
            in_y <= (in_y == YW'(HEIGHT - 1)) ? '0 : in_y + YW'(1);
          end else begin
            in_x <= in_x + XW'(1);
          end
        end

        if (emit) begin
          out_valid    <= 1'b1;
          out_window   <= win_next;
          out_lateral  <= lat_next;
          out_vertical <= vert_next;
          out_color    <= bayer_color(ctr_x[0], ctr_y[0]);
          cur_x        <= ctr_x;
          cur_y        <= ctr_y;
          if (ctr_x == XW'(WIDTH - 1)) begin
            ctr_x <= '0;
            ctr_y <= (ctr_y == YW'(HEIGHT - 1)) ? '0 : ctr_y + YW'(1);
          end else begin
            ctr_x <= ctr_x + XW'(1);
          end
        end else if (out_hs) begin
          out_valid <= 1'b0;
        end

        case (state)
          ST_FILL:  if (accept && fill_done) state <= ST_RUN;
          ST_RUN:   if (accept && in_last)   state <= ST_DRAIN;
          ST_DRAIN: if (out_hs && out_last)  state <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

`ifdef WSTREAM_COORD_EN
  assign out_x = cur_x;
  assign out_y = cur_y;
`endif

endmodule

// File: tb/tb_bayer_window_stream.sv
// Directed bench for bayer_window_stream on a 4x3 frame with pixel value = index+1.
module tb_bayer_window_stream;
  import bayer_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 8;
  localparam int N  = W * H;

  typedef logic [1:-1][1:-1][PW-1:0] win_t;
  typedef struct {
    win_t      win;
    lateral_t  lat;
    vertical_t vert;
    color_t    col;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  win_t          out_window;
  lateral_t      out_lateral;
  vertical_t     out_vertical;
  color_t        out_color;
`ifdef WSTREAM_COORD_EN
  logic [$clog2(W)-1:0] out_x;
  logic [$clog2(H)-1:0] out_y;
`endif

  always #5 clk = ~clk;

  bayer_window_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_lateral(out_lateral), .out_vertical(out_vertical), .out_color(out_color)
`ifdef WSTREAM_COORD_EN
    , .out_x(out_x), .out_y(out_y)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  vec_t          exp_tab[N];
  vec_t          got[$];
  logic [PW:0]   src[$];
  int            stall_from = -1;
  int            stall_len  = 0;
  int            acc6_cyc = -1;
  int            first_valid_cyc = -1;
  int            drain_new = 0;
  bit            prev_stall = 0;
  bit            prev_drain_hs = 0;
  vec_t          prev_out;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic win_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    win_t w;
    w[-1][-1] = PW'(a0); w[-1][0] = PW'(a1); w[-1][1] = PW'(a2);
    w[0][-1]  = PW'(a3); w[0][0]  = PW'(a4); w[0][1]  = PW'(a5);
    w[1][-1]  = PW'(a6); w[1][0]  = PW'(a7); w[1][1]  = PW'(a8);
    return w;
  endfunction

  function automatic int px(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 0;
    return y * W + x + 1;
  endfunction

  function automatic vec_t cur_out();
    vec_t v;
    v.win  = out_window;
    v.lat  = out_lateral;
    v.vert = out_vertical;
    v.col  = out_color;
    return v;
  endfunction

  always @(negedge clk) begin
    vec_t now;
    now = cur_out();
    if (reset) begin
      prev_stall    = 0;
      prev_drain_hs = 0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_win", now.win, prev_out.win);
        check("stall_hold_tags", {now.lat, now.vert, now.col},
              {prev_out.lat, prev_out.vert, prev_out.col});
        check("stall_hold_valid", out_valid, 1'b1);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 1'b0);
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && !in_ready && prev_drain_hs) drain_new++;
      if (out_valid && out_ready) got.push_back(now);
      prev_drain_hs = out_valid && out_ready && !in_ready;
      prev_stall    = out_valid && !out_ready;
      prev_out      = now;
    end
  end

  task automatic run(input int budget, input bit stop_when_sent);
    int t;
    bit done;
    bit sof_now;
    t = 0;
    done = 0;
    while (!done) begin
      if (src.size() > 0) begin
        in_valid = 1'b1;
        {in_sof, in_pixel} = src[0];
      end else begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = '0;
      end
      out_ready = !(stall_from >= 0 && t >= stall_from && t < stall_from + stall_len);
      @(negedge clk);
      sof_now = 0;
      if (in_valid && in_ready) begin
        if (in_pixel == 8'd6 && acc6_cyc < 0) acc6_cyc = cyc;
        sof_now = in_sof;
        void'(src.pop_front());
      end
      @(posedge clk);
      #1;
      t++;
      if (sof_now) check("sof_clears_valid", out_valid, 1'b0);
      if (stop_when_sent ? (src.size() == 0) : (src.size() == 0 && !out_valid && in_ready)) begin
        done = 1;
      end else if (t >= budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL run_timeout: got %0d cycles, required fewer than %0d", t, budget);
        done = 1;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) src.push_back({(i == 0), PW'(i + 1)});
  endtask

  task automatic cmp_frame(input string tag, input int offset);
    check({tag, "_count"}, got.size(), offset + N);
    for (int i = 0; i < N; i++) begin
      if (offset + i < got.size()) begin
        check($sformatf("%s_win%0d", tag, i), got[offset + i].win, exp_tab[i].win);
        check($sformatf("%s_tag%0d", tag, i),
              {got[offset + i].lat, got[offset + i].vert, got[offset + i].col},
              {exp_tab[i].lat, exp_tab[i].vert, exp_tab[i].col});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      int x, y;
      x = i % W;
      y = i / W;
      exp_tab[i].win  = mk(px(x-1, y-1), px(x, y-1), px(x+1, y-1),
                           px(x-1, y),   px(x, y),   px(x+1, y),
                           px(x-1, y+1), px(x, y+1), px(x+1, y+1));
      exp_tab[i].lat  = (x == 0) ? LAT_LEFT : (x == W-1) ? LAT_RIGHT : LAT_CENTER;
      exp_tab[i].vert = (y == 0) ? VERT_TOP : (y == H-1) ? VERT_BOTTOM : VERT_MIDDLE;
      if (x % 2 == 0) exp_tab[i].col = (y % 2 == 0) ? RED : GREEN_BESIDE_BLUE;
      else            exp_tab[i].col = (y % 2 == 0) ? GREEN_BESIDE_RED : BLUE;
    end

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_window", out_window, '0);
    check("rst_tags", {out_lateral, out_vertical, out_color}, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1'b1);

    // Full frame, latency and drain
    got.delete();
    acc6_cyc = -1;
    first_valid_cyc = -1;
    drain_new = 0;
    push_frame();
    run(200, 0);
    cmp_frame("t1", 0);
    if (got.size() >= N) begin
      check("t1_centre11_win", got[5].win, mk(1, 2, 3, 5, 6, 7, 9, 10, 11));
      check("t1_centre11_tag", {got[5].lat, got[5].vert, got[5].col},
            {LAT_CENTER, VERT_MIDDLE, BLUE});
      check("t2_corner00_win", got[0].win, mk(0, 0, 0, 0, 1, 2, 0, 5, 6));
      check("t2_corner00_tag", {got[0].lat, got[0].vert, got[0].col},
            {LAT_LEFT, VERT_TOP, RED});
      check("t2_last32_win", got[11].win, mk(7, 8, 0, 11, 12, 0, 0, 0, 0));
      check("t2_last32_tag", {got[11].lat, got[11].vert, got[11].col},
            {LAT_RIGHT, VERT_BOTTOM, GREEN_BESIDE_RED});
    end
    check("t4_first_latency", first_valid_cyc - acc6_cyc, 1);
    check("t4_drain_windows", drain_new, W + 1);

    // Backpressure mid-RUN
    got.delete();
    stall_from = 8;
    stall_len  = 5;
    push_frame();
    run(200, 0);
    stall_from = -1;
    cmp_frame("t3", 0);

    // Junk before sof, then sof re-asserted at pixel index 7
    got.delete();
    src.push_back({1'b0, 8'hAA});
    src.push_back({1'b0, 8'hBB});
    for (int i = 0; i < 7; i++) src.push_back({(i == 0), PW'(i + 1)});
    push_frame();
    run(200, 0);
    cmp_frame("t5", 2);
    if (got.size() >= 2) begin
      check("t5_abort_win0", got[0].win, exp_tab[0].win);
      check("t5_abort_win1", got[1].win, exp_tab[1].win);
    end

    // Reset while draining
    got.delete();
    push_frame();
    run(200, 1);
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_pixel = 8'h55;
    @(negedge clk);
    check("t6_drain_in_ready", in_ready, 1'b0);
    check("t6_drain_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    @(posedge clk);
    #1;
    check("t6_reset_valid", out_valid, 1'b0);
    check("t6_reset_window", out_window, '0);
    reset = 1'b0;
    #1;
    check("t6_idle_in_ready", in_ready, 1'b1);
    got.delete();
    push_frame();
    run(200, 0);
    cmp_frame("t6", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
